// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA timing receiver: recovers x/y from hsync/vsync and verifies timing lock
module vga_sync_rx #(
  parameter int N         = 11,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pix_en,
  input  logic         hsync,
  input  logic         vsync,
  output logic [N-1:0] x,
  output logic [N-1:0] y,
  output logic         active,
  output logic         frame_start,
  output logic         locked,
  output logic         err
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [N-1:0] CNT_MAX    = '1;
  localparam logic [N-1:0] H_SYNC_END = N'(H_SYNC - 1);
  localparam logic [N-1:0] H_LAST     = N'(H_TOTAL - 1);
  localparam logic [N-1:0] V_SYNC_END = N'(V_SYNC - 1);
  localparam logic [N-1:0] V_LAST     = N'(V_TOTAL - 1);
  localparam logic [N-1:0] H_ACT_LO   = N'(H_SYNC + H_BP);
  localparam logic [N-1:0] H_ACT_HI   = N'(H_SYNC + H_BP + H_VISIBLE);
  localparam logic [N-1:0] V_ACT_LO   = N'(V_SYNC + V_BP);
  localparam logic [N-1:0] V_ACT_HI   = N'(V_SYNC + V_BP + V_VISIBLE);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] hcount_q, hcount_d;
  logic [N-1:0] vcount_q, vcount_d;
  logic         hs_q, hs_d;
  logic         vs_q, vs_d;
  logic         fail_q, fail_d;
  logic         frame_start_q, frame_start_d;
  logic         err_q, err_d;

  logic hs_start, hs_end, vs_start, vs_end;
  logic h_sat, v_sat, check_bad;
  logic h_in, v_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEARCH;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      fail_q        <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      fail_q        <= fail_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    hs_start = pix_en & hs_q & ~hsync;
    hs_end   = pix_en & ~hs_q & hsync;
    vs_start = pix_en & vs_q & ~vsync;
    vs_end   = pix_en & ~vs_q & vsync;
    h_sat    = (hcount_q == CNT_MAX);
    v_sat    = (vcount_q == CNT_MAX);

    // All checks look at the counters before this sample updates them
    check_bad = (hs_end   && (hcount_q != H_SYNC_END)) ||
                (hs_start && (hcount_q != H_LAST))     ||
                (vs_end   && (vcount_q != V_SYNC_END)) ||
                (vs_start && (vcount_q != V_LAST))     ||
                (pix_en   && (h_sat || v_sat));

    hs_d     = pix_en ? hsync : hs_q;
    vs_d     = pix_en ? vsync : vs_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en) begin
      if (hs_start) begin
        hcount_d = '0;
      end else if (!h_sat) begin
        hcount_d = hcount_q + N'(1);
      end
      if (vs_start) begin
        vcount_d = '0;
      end else if (hs_start && !v_sat) begin
        vcount_d = vcount_q + N'(1);
      end
    end

    state_d       = state_q;
    fail_d        = fail_q;
    err_d         = 1'b0;
    frame_start_d = vs_start;
    case (state_q)
      SEARCH: begin
        if (vs_start) begin
          state_d = MEASURE;
          fail_d  = 1'b0;
        end
      end
      MEASURE: begin
        if (vs_start) begin
          if (!fail_q && !check_bad) begin
            state_d = LOCKED;
          end
          fail_d = 1'b0;
        end else if (check_bad) begin
          fail_d = 1'b1;
        end
      end
      LOCKED: begin
        if (check_bad) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    locked      = (state_q == LOCKED);
    h_in        = (hcount_q >= H_ACT_LO) && (hcount_q < H_ACT_HI);
    v_in        = (vcount_q >= V_ACT_LO) && (vcount_q < V_ACT_HI);
    active      = locked & h_in & v_in;
    x           = active ? (hcount_q - H_ACT_LO) : '0;
    y           = active ? (vcount_q - V_ACT_LO) : '0;
    frame_start = frame_start_q;
    err         = err_q;
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - vector table, directed corner sequences and randomized model check for vga_sync_rx
module tb_vga_sync_rx;

  localparam int HVIS = 8, HF = 2, HS = 3, HB = 3, HT = 16;
  localparam int VVIS = 4, VF = 1, VS = 2, VB = 1, VT = 8;
  localparam int CMAX = 2047;

  logic        clk, rst, pix_en, hsync, vsync;
  logic [10:0] x, y;
  logic        active, frame_start, locked, err;

  vga_sync_rx #(
    .N(11), .H_VISIBLE(HVIS), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VVIS), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .active(active), .frame_start(frame_start),
    .locked(locked), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Reference model: counters are expressed as distances between sample indices
  int samp = 0, hs_cnt = 0, h_ref = 0, l_ref = 0;
  int mode = 0;
  bit p_hs = 1, p_vs = 1, fail = 0, e_fs = 0, e_err = 0;

  function automatic int hc();
    return (samp - h_ref > CMAX) ? CMAX : samp - h_ref;
  endfunction

  function automatic int vc();
    return (hs_cnt - l_ref > CMAX) ? CMAX : hs_cnt - l_ref;
  endfunction

  task automatic model_reset();
    p_hs = 1; p_vs = 1; h_ref = samp; l_ref = hs_cnt;
    mode = 0; fail = 0; e_fs = 0; e_err = 0;
  endtask

  task automatic model_sample(input bit hs, input bit vs);
    bit hss, hse, vss, vse, bad;
    int ch, cv;
    hss = p_hs && !hs; hse = !p_hs && hs;
    vss = p_vs && !vs; vse = !p_vs && vs;
    ch = hc(); cv = vc();
    bad = (hse && ch != HS - 1) || (hss && ch != HT - 1) ||
          (vse && cv != VS - 1) || (vss && cv != VT - 1) ||
          ch == CMAX || cv == CMAX;
    e_fs  = vss;
    e_err = (mode == 2) && bad;
    if (mode == 0) begin
      if (vss) begin mode = 1; fail = 0; end
    end else if (mode == 1) begin
      if (vss) begin
        if (!fail && !bad) mode = 2;
        fail = 0;
      end else if (bad) begin
        fail = 1;
      end
    end else if (bad) begin
      mode = 0;
    end
    samp++;
    if (hss) begin h_ref = samp; hs_cnt++; end
    if (vss) l_ref = hs_cnt;
    p_hs = hs; p_vs = vs;
  endtask

  function automatic logic [31:0] model_out();
    int h, v;
    bit lk, act;
    h = hc(); v = vc();
    lk = (mode == 2);
    act = lk && h >= HS + HB && h < HS + HB + HVIS && v >= VS + VB && v < VS + VB + VVIS;
    return {6'd0, act ? 11'(h - HS - HB) : 11'd0, act ? 11'(v - VS - VB) : 11'd0,
            act, e_fs, lk, e_err};
  endfunction

  function automatic logic [31:0] dut_out();
    return {6'd0, x, y, active, frame_start, locked, err};
  endfunction

  task automatic step(input logic r, input logic en, input logic hs, input logic vs);
    rst = r; pix_en = en; hsync = hs; vsync = vs;
    @(posedge clk);
    if (r) model_reset();
    else if (en) model_sample(hs, vs);
    else begin e_fs = 0; e_err = 0; end
    #1;
    chk("model", dut_out(), model_out());
  endtask

  int pos = 0;

  function automatic logic ihs(input int p);
    return ((p % HT) < HS) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic ivs(input int p);
    return (((p / HT) % VT) < VS) ? 1'b0 : 1'b1;
  endfunction

  task automatic ideal_step();
    step(1'b0, 1'b1, ihs(pos), ivs(pos));
    pos++;
  endtask

  task automatic run_until(input int t);
    while (pos < t) ideal_step();
  endtask

  typedef struct packed {
    logic r, en, hs, vs;
    logic [10:0] ex, ey;
    logic act, fs, lk, er;
  } vec_t;

  function automatic vec_t mk(input logic r, en, hs, vs, act, fs, lk, er);
    vec_t v;
    v.r = r; v.en = en; v.hs = hs; v.vs = vs;
    v.ex = '0; v.ey = '0;
    v.act = act; v.fs = fs; v.lk = lk; v.er = er;
    return v;
  endfunction

  vec_t tbl[8];
  int   act_cnt, err_cnt, h, l;
  bit   ea;

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;

    // reset with toggling syncs, then the first samples of ideal timing (pos 0..3)
    tbl[0] = mk(1, 1, 0, 1, 0, 0, 0, 0);
    tbl[1] = mk(1, 1, 1, 0, 0, 0, 0, 0);
    tbl[2] = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(1, 0, 1, 1, 0, 0, 0, 0);
    tbl[4] = mk(0, 1, 0, 0, 0, 1, 0, 0);
    tbl[5] = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[6] = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[7] = mk(0, 1, 1, 0, 0, 0, 0, 0);
    #2;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].en, tbl[i].hs, tbl[i].vs);
      chk($sformatf("tbl%0d", i), dut_out(),
          {6'd0, tbl[i].ex, tbl[i].ey, tbl[i].act, tbl[i].fs, tbl[i].lk, tbl[i].er});
    end
    pos = 4;

    // lock only after the second vs_start, 128 pixels after the first
    run_until(128);
    chk("lock_early", locked, 0);
    ideal_step();
    chk("lock_2nd_vs", locked, 1);
    chk("fs_2nd_vs", frame_start, 1);

    // line vcount=3 of a locked frame
    run_until(256 + 3 * HT);
    act_cnt = 0;
    for (int hh = 0; hh < HT; hh++) begin
      ideal_step();
      if (active) act_cnt++;
      if (hh == 5)  chk("act_before", active, 0);
      if (hh == 6)  chk("first_vis", {active, x, y}, {1'b1, 11'd0, 11'd0});
      if (hh == 13) chk("last_vis_x", {active, x, y}, {1'b1, 11'd7, 11'd0});
      if (hh == 14) chk("act_after", active, 0);
    end
    chk("act_width", act_cnt, 8);
    run_until(256 + 6 * HT + 14);
    chk("last_line", {active, x, y}, {1'b1, 11'd7, 11'd3});
    run_until(256 + 7 * HT + 7);
    chk("line7_blank", active, 0);

    // shortened hsync pulse while locked
    run_until(416);
    ideal_step();
    ideal_step();
    step(1'b0, 1'b1, 1'b1, ivs(pos));
    pos++;
    chk("short_hs_err", {err, locked, active}, 3'b100);
    ideal_step();
    chk("err_width", err, 0);
    run_until(513);
    chk("relock_measure", locked, 0);
    run_until(640);
    chk("relock_early", locked, 0);
    ideal_step();
    chk("relock", locked, 1);

    // pix_en on every third clock
    while (pos < 800) begin
      step(1'b0, 1'b0, ihs(pos), ivs(pos));
      if (pos == 769) chk("fs_gated_width", frame_start, 0);
      step(1'b0, 1'b0, ihs(pos), ivs(pos));
      step(1'b0, 1'b1, ihs(pos), ivs(pos));
      h = pos % HT;
      l = (pos / HT) % VT;
      ea = (h >= 6 && h < 14 && l >= 3 && l < 7);
      chk($sformatf("gated_xy_p%0d", pos), {active, x, y},
          {ea, ea ? 11'(h - 6) : 11'd0, ea ? 11'(l - 3) : 11'd0});
      if (pos == 768) chk("fs_gated", frame_start, 1);
      pos++;
    end

    // asynchronous reset on line vcount=5
    run_until(768 + 5 * HT + 4);
    chk("pre_reset_locked", locked, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", locked, 0);
    model_reset();
    step(1'b1, 1'b1, ihs(pos), ivs(pos));
    pos++;
    step(1'b1, 1'b1, ihs(pos), ivs(pos));
    pos++;
    run_until(897);
    chk("rst_relock_1st", locked, 0);
    run_until(1024);
    chk("rst_relock_early", locked, 0);
    ideal_step();
    chk("rst_relock_2nd", locked, 1);

    // hsync stops while locked: hcount saturates and lock drops exactly once
    run_until(1024 + 3 * HT + 8);
    err_cnt = 0;
    for (int i = 0; i < 2100; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      if (err) err_cnt++;
    end
    chk("sat_err_count", err_cnt, 1);
    chk("sat_unlocked", locked, 0);

    // randomized: ideal timing with rare glitches, random pix_en and rare resets
    pos = 0;
    for (int i = 0; i < 3000; i++) begin
      logic en, r, hs, vs;
      en = ($urandom_range(3) != 0);
      r  = ($urandom_range(999) == 0);
      hs = ihs(pos) ^ ($urandom_range(299) == 0);
      vs = ivs(pos) ^ ($urandom_range(299) == 0);
      step(r, en, hs, vs);
      if (en) pos++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
